// File: rtl/spi_adc_sampler_pkg.sv
// Shared types, width helpers and parameter checks for the SPI ADC sampler.
package spi_adc_pkg;

    // Frame sequencer states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LEAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_TAIL  = 2'd3;

    // Bits needed to hold the values 0..n-1 (at least one bit)
    function automatic int cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of the clk-cycles-per-half-period counter
    function automatic int div_cnt_w(input int unsigned clk_div_half);
        return cnt_w(clk_div_half);
    endfunction

    // Width of the bit counter, which must reach FRAME_BITS without wrapping
    function automatic int bit_cnt_w(input int unsigned frame_bits);
        return cnt_w(frame_bits + 1);
    endfunction

    // Legal parameter combinations
    function automatic bit params_ok(input int unsigned clk_div_half,
                                     input int unsigned frame_bits,
                                     input int unsigned lead_bits,
                                     input int unsigned data_w,
                                     input int unsigned repeat_gap);
        return (clk_div_half >= 2) && (frame_bits >= 2) && (frame_bits <= 32) &&
               (data_w >= 1) && (lead_bits + data_w <= frame_bits) &&
               (repeat_gap >= 1);
    endfunction

endpackage

// File: rtl/spi_adc_sampler_if.sv
// SPI pins plus the valid/ready sample stream of the ADC sampler.
interface spi_adc_sampler_if #(
    parameter int unsigned DATA_W = 12
);
    logic              cs_n;
    logic              sclk;
    logic              sdata;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              data_ready;
    logic              overrun;

    // Sampler side: drives the SPI bus and produces samples
    modport master (
        output cs_n, sclk, data, data_valid, overrun,
        input  sdata, data_ready
    );

    // ADC plus consumer side
    modport slave (
        input  cs_n, sclk, data, data_valid, overrun,
        output sdata, data_ready
    );
endinterface

// File: rtl/spi_adc_sampler_sclk_gen.sv
// Half-period timer and serial clock generator for the SPI ADC sampler.
// The timer runs whenever en is high; sclk only toggles while tog_en is high,
// so the same timer also paces the cs_n setup and hold phases.
module spi_sclk_gen
    import spi_adc_pkg::*;
#(
    parameter int unsigned CLK_DIV_HALF = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tog_en,
    output logic sclk,
    output logic tick_c,
    output logic fall_stb_c,
    output logic rise_stb_c
);

    localparam int unsigned HC_W = div_cnt_w(CLK_DIV_HALF);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(CLK_DIV_HALF - 1);

    logic [HC_W-1:0] hc_q;

    // End of a half-period and the sclk edge it produces on this clk edge
    assign tick_c     = en && (hc_q == HC_MAX);
    assign fall_stb_c = tick_c && tog_en && sclk;
    assign rise_stb_c = tick_c && tog_en && !sclk;

    // Half-period counter and sclk register; sclk idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q <= '0;
            sclk <= 1'b1;
        end else begin
            if (!en || tick_c) begin
                hc_q <= '0;
            end else begin
                hc_q <= hc_q + 1'b1;
            end
            if (!en) begin
                sclk <= 1'b1;
            end else if (fall_stb_c || rise_stb_c) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/spi_adc_sampler.sv
// SPI master reading serial ADC frames into a valid/ready sample register.
// Optional free-running mode: define SPI_ADC_AUTO_REPEAT_EN to add the auto_en
// port, which restarts a frame REPEAT_GAP clks after each cs_n rise.
module spi_adc_sampler
    import spi_adc_pkg::*;
#(
    parameter int unsigned CLK_DIV_HALF = 12,
    parameter int unsigned FRAME_BITS   = 16,
    parameter int unsigned LEAD_BITS    = 4,
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned REPEAT_GAP   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SPI_ADC_AUTO_REPEAT_EN
    input  logic               auto_en,
`endif
    output logic               busy,
    spi_adc_sampler_if.master  bus
);

    localparam int unsigned BC_W = bit_cnt_w(FRAME_BITS);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS - 1);
    localparam logic [BC_W-1:0] BC_LO   = BC_W'(LEAD_BITS);
    localparam logic [BC_W-1:0] BC_HI   = BC_W'(LEAD_BITS + DATA_W);

    // Reject illegal configurations at elaboration
    if (!params_ok(CLK_DIV_HALF, FRAME_BITS, LEAD_BITS, DATA_W, REPEAT_GAP)) begin : g_param_check
        $error("spi_adc_sampler: illegal parameter combination");
    end

    state_t            state_q, state_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              load_c;
    logic              auto_fire_c;
    logic              tick_c, fall_stb_c, rise_stb_c;
    logic              in_window_c;

    spi_sclk_gen #(
        .CLK_DIV_HALF (CLK_DIV_HALF)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q != ST_IDLE),
        .tog_en     ((state_q == ST_LEAD) || (state_q == ST_SHIFT)),
        .sclk       (bus.sclk),
        .tick_c     (tick_c),
        .fall_stb_c (fall_stb_c),
        .rise_stb_c (rise_stb_c)
    );

`ifdef SPI_ADC_AUTO_REPEAT_EN
    localparam int unsigned GAP_W = cnt_w(REPEAT_GAP);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(REPEAT_GAP - 1);

    logic [GAP_W-1:0] gap_q, gap_d;

    assign auto_fire_c = auto_en && (gap_q == GAP_MAX);

    // Idle-gap counter: restarts at each cs_n rise, saturates at the gap length
    always_comb begin
        gap_d = gap_q;
        if (load_c) begin
            gap_d = '0;
        end else if ((state_q == ST_IDLE) && (gap_q != GAP_MAX)) begin
            gap_d = gap_q + 1'b1;
        end
    end

    // Idle-gap counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`else
    assign auto_fire_c = 1'b0;
`endif

    assign in_window_c = (bit_cnt_q >= BC_LO) && (bit_cnt_q < BC_HI);

    // Frame sequencer, shift register and output handshake next-state logic
    always_comb begin
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        load_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start || auto_fire_c) begin
                    state_d   = ST_LEAD;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_LEAD: begin
                if (fall_stb_c) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_stb_c) begin
                    if (in_window_c) begin
                        shreg_d = DATA_W'({shreg_q, bus.sdata});
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BC_LAST) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (tick_c) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    load_c  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new sample always wins over a same-edge consume
        if (load_c) begin
            data_d    = shreg_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !bus.data_ready;
        end else if (valid_q && bus.data_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.cs_n       = cs_n_q;
    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = overrun_q;
    assign busy           = busy_q;

endmodule
